// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding for the serial shift controller
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } serial_state_t;

endpackage

// File: rtl/shift_chain.sv
// rtl/shift_chain.sv - parallel-load shift register, serial bit enters at bit 0
module shift_chain #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d_par,
    input  logic             d_ser,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d_par;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], d_ser};
        end
    end

endmodule

// File: rtl/serial_shift_ctrl.sv
// rtl/serial_shift_ctrl.sv - word serializer/deserializer with divided bit clock
module serial_shift_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             sdi,
    output logic             sdo,
    output logic             shift_en,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    input  logic             rx_ready,
    input  logic             abort,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = $clog2(DIV) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    serial_state_t    state;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    logic [WIDTH-1:0] chain;
    logic             in_idle;
    logic             chain_load;
    logic [WIDTH-1:0] chain_par;

    assign in_idle = (state == ST_IDLE);

    // Abort suppresses the shift so a cancelled transfer never shows a stray strobe.
    assign shift_en   = (state == ST_SHIFT) && (div_cnt == DIV_LAST) && !abort;
    assign chain_load = in_idle ? tx_valid : abort;
    assign chain_par  = in_idle ? tx_data : '0;
    assign sdo        = !in_idle && chain[WIDTH-1];
    assign rx_data    = chain;

    shift_chain #(
        .WIDTH(WIDTH)
    ) u_chain (
        .clk  (clk),
        .rst_n(rst_n),
        .load (chain_load),
        .shift(shift_en),
        .d_par(chain_par),
        .d_ser(sdi),
        .q    (chain)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            tx_ready <= 1'b1;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        state    <= ST_SHIFT;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state    <= ST_HOLD;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (abort || rx_ready) begin
                        state    <= ST_IDLE;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        tx_ready <= 1'b1;
                        rx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    tx_ready <= 1'b1;
                    rx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// tb/tb_serial_shift_ctrl.sv - directed self-checking bench for serial_shift_ctrl
module tb_serial_shift_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid, rx_ready, abort, sdi_drv, loop_en;
    logic [3:0] tx_data;
    logic       tx_ready, sdo, shift_en, rx_valid, busy;
    logic [3:0] rx_data;
    logic       sdi;

    logic       tx_valid_b, rx_ready_b, abort_b;
    logic [3:0] tx_data_b;
    logic       tx_ready_b, sdo_b, shift_en_b, rx_valid_b, busy_b;
    logic [3:0] rx_data_b;
    logic       sdi_b;

    int checks = 0;
    int errors = 0;

    logic [0:7]  se_a, sd_a1, sd_a2;
    logic [0:11] se_b, sd_b, rv_b, tr_b;
    logic [7:0]  exp_st;

    always #5 clk = ~clk;

    assign sdi   = loop_en ? sdo : sdi_drv;
    assign sdi_b = sdo_b;

    // status word: {tx_ready, busy, rx_valid, shift_en, sdo}
    wire [7:0] st_a = {3'b000, tx_ready, busy, rx_valid, shift_en, sdo};
    wire [7:0] st_b = {3'b000, tx_ready_b, busy_b, rx_valid_b, shift_en_b, sdo_b};
    wire [7:0] rd_a = {4'h0, rx_data};
    wire [7:0] rd_b = {4'h0, rx_data_b};

    serial_shift_ctrl #(.WIDTH(4), .DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .sdi(sdi), .sdo(sdo), .shift_en(shift_en),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .abort(abort), .busy(busy)
    );

    serial_shift_ctrl #(.WIDTH(4), .DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
        .tx_ready(tx_ready_b), .sdi(sdi_b), .sdo(sdo_b), .shift_en(shift_en_b),
        .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
        .abort(abort_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 4'h0; rx_ready = 1'b0;
        abort = 1'b0; sdi_drv = 1'b0; loop_en = 1'b0;
        tx_valid_b = 1'b0; tx_data_b = 4'h0; rx_ready_b = 1'b1; abort_b = 1'b0;
        se_a  = 8'b0101_0101;
        sd_a1 = 8'b1100_1111;
        sd_a2 = 8'b0011_1100;
        se_b  = 12'b1111_0011_1100;
        sd_b  = 12'b1001_1000_1100;
        rv_b  = 12'b0000_1000_0010;
        tr_b  = 12'b0000_0100_0001;

        tick(); tick();
        chk("reset_status", st_a, 8'b000_10000);
        chk("reset_rx_data", rd_a, 8'h00);
        chk("reset_status_b", st_b, 8'b000_10000);
        rst_n = 1'b1;

        // 1011 out with sdi held low
        tx_data = 4'b1011; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_st = {3'b000, 1'b0, 1'b1, 1'b0, se_a[k], sd_a1[k]};
            chk($sformatf("tx1011_k%0d", k), st_a, exp_st);
            tick();
        end
        chk("tx1011_hold", st_a, 8'b000_01100);
        chk("tx1011_rx_data", rd_a, 8'h00);
        rx_ready = 1'b1;
        tick();
        chk("tx1011_idle", st_a, 8'b000_10000);
        rx_ready = 1'b0;

        // loopback 0110, then stall the consumer in HOLD
        loop_en = 1'b1; tx_data = 4'b0110; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_st = {3'b000, 1'b0, 1'b1, 1'b0, se_a[k], sd_a2[k]};
            chk($sformatf("loop_k%0d", k), st_a, exp_st);
            tick();
        end
        chk("loop_hold", st_a, 8'b000_01100);
        chk("loop_rx_data", rd_a, 8'h06);
        for (int s = 0; s < 5; s++) begin
            tick();
            chk($sformatf("stall_status_%0d", s), st_a, 8'b000_01100);
            chk($sformatf("stall_rx_data_%0d", s), rd_a, 8'h06);
        end
        rx_ready = 1'b1;
        #1;
        chk("stall_release", st_a, 8'b000_01100);
        tick();
        chk("stall_idle", st_a, 8'b000_10000);
        rx_ready = 1'b0; loop_en = 1'b0;

        // abort on the third shift cycle, after two shifts
        tx_data = 4'b1010; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (5) tick();
        chk("pre_abort", st_a, 8'b000_01011);
        abort = 1'b1;
        #1;
        chk("abort_gates_shift", st_a, 8'b000_01001);
        tick();
        chk("abort_idle", st_a, 8'b000_10000);
        chk("abort_chain_clear", rd_a, 8'h00);
        tx_data = 4'b1111; tx_valid = 1'b1; sdi_drv = 1'b1;
        tick();
        chk("abort_idle_accept", st_a, 8'b000_01001);
        abort = 1'b0; tx_valid = 1'b0;
        repeat (7) tick();
        chk("tx1111_k7", st_a, 8'b000_01011);
        tick();
        chk("tx1111_hold", st_a, 8'b000_01101);
        chk("tx1111_rx_data", rd_a, 8'h0F);
        rx_ready = 1'b1;
        tick();
        chk("tx1111_idle", st_a, 8'b000_10000);
        rx_ready = 1'b0; sdi_drv = 1'b0;

        // asynchronous reset in the middle of a transfer
        tx_data = 4'b1101; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick(); tick();
        chk("pre_reset_shift", st_a, 8'b000_01001);
        rst_n = 1'b0;
        #1;
        chk("async_reset_status", st_a, 8'b000_10000);
        chk("async_reset_rx_data", rd_a, 8'h00);
        tx_data = 4'b0101; tx_valid = 1'b1;
        tick();
        chk("in_reset_no_accept", st_a, 8'b000_10000);
        rst_n = 1'b1;
        tick();
        chk("post_reset_accept", st_a, 8'b000_01000);
        abort = 1'b1; tx_valid = 1'b0;
        tick();
        chk("post_reset_abort", st_a, 8'b000_10000);
        abort = 1'b0;

        // DIV=1, back-to-back words with loopback and rx_ready held high
        tx_data_b = 4'b1001; tx_valid_b = 1'b1;
        tick();
        tx_data_b = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            exp_st = {3'b000, tr_b[k], ~tr_b[k], rv_b[k], se_b[k], sd_b[k]};
            chk($sformatf("div1_k%0d", k), st_b, exp_st);
            if (k == 4) chk("div1_rx_data_w0", rd_b, 8'h09);
            if (k == 10) chk("div1_rx_data_w1", rd_b, 8'h03);
            if (k == 6) tx_valid_b = 1'b0;
            tick();
        end
        chk("div1_final_idle", st_b, 8'b000_10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_shift_ctrl.md
SERIAL_SHIFT_CTRL -- requirements
Module: serial_shift_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: shift-chain width in bits; legal range >= 2.
REQ-002 The block SHALL have parameter DIV, default 2: clock cycles per serial bit; legal range >= 1.
REQ-003 The block SHALL use one clock, with reset asynchronous and active-low, on ports clk and rst_n.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port tx_valid, input, 1 bit: a parallel word is offered on tx_data.
REQ-007 Port tx_data, input, WIDTH bits: word to serialize, MSB first.
REQ-008 Port tx_ready, output, 1 bit: the controller accepts a word this cycle.
REQ-009 Port sdi, input, 1 bit: serial data in, shifted into bit 0.
REQ-010 Port sdo, output, 1 bit: serial data out, equal to chain[WIDTH-1].
REQ-011 Port shift_en, output, 1 bit: one-cycle strobe marking each shift edge.
REQ-012 Port rx_valid, output, 1 bit: rx_data holds a completed received word.
REQ-013 Port rx_data, output, WIDTH bits: received word, first bit in MSB.
REQ-014 Port rx_ready, input, 1 bit: the consumer takes rx_data.
REQ-015 Port abort, input, 1 bit: synchronous cancel of the current transfer.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SHIFT and HOLD.
REQ-018 tx_ready SHALL be 1 only in IDLE; rx_valid SHALL be 1 only in HOLD.
REQ-019 In IDLE, when tx_valid is 1, the controller SHALL load chain <= tx_data, clear bit_cnt and div_cnt, and go to SHIFT.
REQ-020 In SHIFT, div_cnt SHALL count 0..DIV-1 and wrap; shift_en SHALL be 1 exactly in cycles where div_cnt == DIV-1.
REQ-021 On a shift_en cycle, chain SHALL update to {chain[WIDTH-2:0], sdi} and bit_cnt SHALL increment; sdi is sampled only in that cycle.
REQ-022 On the shift_en cycle with bit_cnt == WIDTH-1, the FSM SHALL go to HOLD, and rx_data SHALL equal the post-shift chain.
REQ-023 Latency: rx_valid SHALL rise exactly WIDTH*DIV cycles after the accept edge; each sdo bit SHALL be held for DIV cycles.
REQ-024 In HOLD, rx_valid and rx_data SHALL stay stable until rx_valid and rx_ready are both 1; the FSM then returns to IDLE with tx_ready = 1 on the following cycle.
REQ-025 Back-to-back transfers SHALL cost exactly one IDLE cycle between a HOLD handshake and the next accept.
REQ-026 In IDLE, sdo and shift_en SHALL be 0; in HOLD, shift_en SHALL be 0 and sdo SHALL equal chain[WIDTH-1].
REQ-027 Abort SHALL force the FSM to IDLE on the next edge from SHIFT or HOLD, with no further shift_en, no rx_valid and the chain cleared.
REQ-028 Abort SHALL take priority over a same-cycle shift or rx handshake.
REQ-029 Abort in IDLE SHALL be ignored, and a same-cycle tx_valid SHALL still be accepted.
REQ-030 When DIV = 1, shift_en SHALL be 1 on every SHIFT cycle.

Reset
REQ-031 While rst_n = 0, the block SHALL hold state = IDLE, chain = 0, bit_cnt = 0 and div_cnt = 0, asynchronously.
REQ-032 Reset values of the outputs SHALL be: tx_ready = 1, sdo = 0, shift_en = 0, rx_valid = 0, rx_data = 0, busy = 0.
REQ-033 Reset asserted mid-transfer SHALL discard the transfer; after deassertion, the first accept SHALL occur on the first edge where tx_valid = 1.

Structure
REQ-034 The state enum for IDLE, SHIFT and HOLD SHALL live in the shared package serial_pkg.
REQ-035 Counters SHALL be sized $clog2(WIDTH) and $clog2(DIV)+1 bits, kept in the module.
REQ-036 The parallel-load shift chain SHALL be one sub-module, shift_chain (ports: clk, rst_n, load, shift, d_par, d_ser, q), instantiated once.

Verification (WIDTH=4, DIV=2 unless stated)
REQ-037 sdi tied 0, tx_data = 4'b1011: sdo = 1,0,1,1, each held 2 cycles; shift_en pulses 4 times; rx_data = 4'b0000 at cycle 8 after accept.
REQ-038 sdi looped to sdo, tx_data = 4'b0110: rx_valid rises 8 cycles after accept with rx_data = 4'b0110.
REQ-039 rx_ready held 0 for 5 cycles in HOLD: rx_valid and rx_data remain stable and tx_ready stays 0; on rx_ready = 1, tx_ready = 1 the next cycle.
REQ-040 abort pulsed after the 2nd shift_en: IDLE on the next cycle, sdo = 0, no rx_valid, and a new tx_data = 4'b1111 is accepted normally.
REQ-041 rst_n = 0 mid-SHIFT: all outputs take reset values immediately, without waiting for a clock edge.
REQ-042 DIV = 1, two back-to-back words 4'b1001 then 4'b0011 with rx_ready = 1: shift_en high on 4 consecutive cycles per word, with exactly one IDLE cycle between the words.
